// File: rtl/mano_pkg.sv
// Shared constants and the loader state type, also used by the Mano CPU core.
package mano_pkg;
    localparam int MANO_DEPTH = 9;
    localparam int MANO_AW    = 4;
    localparam int MANO_DW    = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        WRITE  = 2'd2,
        DONE   = 2'd3
    } mano_state_t;
endpackage

// File: rtl/mano_mem_loader_if.sv
// Host byte-load handshake plus CPU MAR->MBR read bus; master = host/CPU side, slave = loader.
interface mano_mem_loader_if #(
    parameter int AW = mano_pkg::MANO_AW,
    parameter int DW = mano_pkg::MANO_DW
);
    logic          ld_start;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_ready;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_oor;
    logic          busy;
    logic          load_done;
    logic [AW-1:0] wr_ptr;

    modport master (
        output ld_start, ld_valid, ld_data, rd_req, rd_addr,
        input  ld_ready, rd_data, rd_valid, rd_oor, busy, load_done, wr_ptr
    );

    modport slave (
        input  ld_start, ld_valid, ld_data, rd_req, rd_addr,
        output ld_ready, rd_data, rd_valid, rd_oor, busy, load_done, wr_ptr
    );
endinterface

// File: rtl/mano_mem_array.sv
// Program memory: DEPTH x DW registers, one sync write port, one registered read port.
// Latency: read data and out-of-range flag valid 1 cycle after rd_en.
// Backpressure: none; every rd_en produces exactly one rd_valid pulse.
module mano_mem_array
    import mano_pkg::*;
#(
    parameter int DEPTH = MANO_DEPTH,
    parameter int AW    = MANO_AW,
    parameter int DW    = MANO_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          rd_oor
);
    logic [DW-1:0] mem [DEPTH];
    logic          in_range;

    // One extra bit so the compare also works when DEPTH == 2**AW.
    assign in_range = {1'b0, rd_addr} < (AW+1)'(DEPTH);

    // Contents are deliberately left unreset; they are undefined until loaded.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_oor   <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= in_range ? mem[rd_addr] : '0;
                rd_oor  <= !in_range;
            end
        end
    end
endmodule

// File: rtl/mano_mem_loader.sv
// Loads DEPTH program bytes from the pad-side host into program memory and serves CPU reads.
// Latency: one byte accepted per 2 cycles; CPU reads return 1 cycle after rd_req.
// Backpressure: ld_ready only in ACCEPT; rd_req is dropped while busy and must be re-issued.
module mano_mem_loader
    import mano_pkg::*;
#(
    parameter int DEPTH = MANO_DEPTH,
    parameter int AW    = MANO_AW,
    parameter int DW    = MANO_DW
) (
    input  logic                clk,
    input  logic                rst,
    mano_mem_loader_if.slave    bus
);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    mano_state_t   state_q;
    logic [AW-1:0] wr_ptr_q;
    logic [DW-1:0] byte_q;
    logic          ld_ready_q;
    logic          busy_q;
    logic          done_q;
    logic          mem_we;
    logic          rd_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            byte_q     <= '0;
            ld_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else if (bus.ld_start) begin
            // Start or restart from any state; an in-flight WRITE is dropped.
            state_q    <= ACCEPT;
            wr_ptr_q   <= '0;
            ld_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                ACCEPT: begin
                    if (bus.ld_valid && ld_ready_q) begin
                        byte_q     <= bus.ld_data;
                        ld_ready_q <= 1'b0;
                        state_q    <= WRITE;
                    end
                end
                WRITE: begin
                    if (wr_ptr_q == LAST_ADDR) begin
                        wr_ptr_q <= '0;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= DONE;
                    end else begin
                        wr_ptr_q   <= wr_ptr_q + AW'(1);
                        ld_ready_q <= 1'b1;
                        state_q    <= ACCEPT;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_we = (state_q == WRITE) && !bus.ld_start;
    assign rd_en  = bus.rd_req && !busy_q;

    mano_mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_mem (
        .clk      (clk),
        .rst      (rst),
        .we       (mem_we),
        .wr_addr  (wr_ptr_q),
        .wr_data  (byte_q),
        .rd_en    (rd_en),
        .rd_addr  (bus.rd_addr),
        .rd_data  (bus.rd_data),
        .rd_valid (bus.rd_valid),
        .rd_oor   (bus.rd_oor)
    );

    assign bus.ld_ready  = ld_ready_q;
    assign bus.busy      = busy_q;
    assign bus.load_done = done_q;
    assign bus.wr_ptr    = wr_ptr_q;
endmodule
